uart_rx: RTL and testbench

- Serial receiver for the UART path. It is the counterpart of uart_tx and consumes the serial line that uart_tx produces.
- Shares the baudrate_generator tick, which runs at 16x oversampling.
- Synchronises the line, detects the start bit, samples each data bit at mid-bit, and checks the stop bit.
- Presents a received byte with a one-cycle done strobe and a framing-error flag.

---
 rtl/uart_rx.sv | 149 ++++++++++++++
 tb/tb_uart_rx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled serial receiver.
// Mid-bit sampling, stop-bit check, one-clk done strobe.
module uart_rx #(
   parameter int NB_DATA = 8,
   parameter int NB_STOP = 16
) (
   input  logic               clk,
   input  logic               i_rst,
   input  logic               i_tick,
   input  logic               i_rx,
   output logic [NB_DATA-1:0] o_data,
   output logic               o_rx_done,
   output logic               o_frame_err
);

   localparam int TW_RAW = $clog2(NB_STOP);
   localparam int TW     = (TW_RAW > 4) ? TW_RAW : 4;
   localparam int BW     = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

   localparam logic [TW-1:0] TICK_MID  = TW'(7);
   localparam logic [TW-1:0] TICK_END  = TW'(15);
   localparam logic [TW-1:0] TICK_STOP = TW'(NB_STOP - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(NB_DATA - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t state_q, state_d;

   logic rx_meta;
   logic rx_s;

   logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
   logic [BW-1:0]      bit_cnt_q,  bit_cnt_d;
   logic [NB_DATA-1:0] shift_q,    shift_d;
   logic [NB_DATA-1:0] data_q,     data_d;
   logic               done_q,     done_d;
   logic               ferr_q,     ferr_d;

   // two-flop synchroniser; idle-high so reset never fakes a start edge
   always_ff @(posedge clk) begin
      if (i_rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= i_rx;
         rx_s    <= rx_meta;
      end
   end

   // state, counters and output registers
   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         done_q     <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         done_q     <= done_d;
         ferr_q     <= ferr_d;
      end
   end

   // next-state: start qualify at 8 ticks, then one sample every 16
   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      data_d     = data_q;
      done_d     = 1'b0;
      ferr_d     = ferr_q;

      unique case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d    = START;
               tick_cnt_d = '0;
            end
         end

         START: begin
            if (i_tick) begin
               if (tick_cnt_q == TICK_MID) begin
                  if (!rx_s) begin
                     state_d    = DATA;
                     tick_cnt_d = '0;
                     bit_cnt_d  = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TW'(1);
               end
            end
         end

         DATA: begin
            if (i_tick) begin
               if (tick_cnt_q == TICK_END) begin
                  tick_cnt_d = '0;
                  shift_d    = {rx_s, shift_q[NB_DATA-1:1]};
                  if (bit_cnt_q == BIT_LAST) begin
                     state_d = STOP;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BW'(1);
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TW'(1);
               end
            end
         end

         STOP: begin
            if (i_tick) begin
               if (tick_cnt_q == TICK_STOP) begin
                  state_d = IDLE;
                  data_d  = shift_q;
                  ferr_d  = ~rx_s;
                  done_d  = 1'b1;
               end else begin
                  tick_cnt_d = tick_cnt_q + TW'(1);
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign o_data      = data_q;
   assign o_rx_done   = done_q;
   assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx.
// Bench-modelled transmitter drives i_rx; immediate assertions check results.
module tb_uart_rx;

   localparam int DIV = 8;

   logic       clk = 1'b0;
   logic       i_rst;
   logic       i_tick;
   logic       i_rx;
   logic [7:0] o_data;
   logic       o_rx_done;
   logic       o_frame_err;

   int n_chk = 0;
   int n_fail = 0;

   int bit_clks = 16 * DIV;
   bit tick_hi = 1'b0;
   int div_cnt = 0;

   int         done_cnt = 0;
   int         wide_cnt = 0;
   logic       prev_done = 1'b0;
   logic [7:0] cap_data[$];
   logic       cap_err[$];

   int         n0;
   logic [7:0] exp2 [3];

   always #5 clk = ~clk;

   uart_rx #(
      .NB_DATA (8),
      .NB_STOP (16)
   ) dut (
      .clk         (clk),
      .i_rst       (i_rst),
      .i_tick      (i_tick),
      .i_rx        (i_rx),
      .o_data      (o_data),
      .o_rx_done   (o_rx_done),
      .o_frame_err (o_frame_err)
   );

   // tick source: divide-by-DIV, or held high for fast mode
   initial begin : tick_gen
      i_tick = 1'b0;
      forever begin
         @(negedge clk);
         if (tick_hi) begin
            i_tick = 1'b1;
         end else begin
            i_tick  = (div_cnt == DIV - 1);
            div_cnt = (div_cnt == DIV - 1) ? 0 : div_cnt + 1;
         end
      end
   end

   // capture every done pulse and flag pulses wider than one clk
   initial begin : mon
      forever begin
         @(negedge clk);
         if (o_rx_done === 1'b1) begin
            done_cnt++;
            cap_data.push_back(o_data);
            cap_err.push_back(o_frame_err);
            if (prev_done === 1'b1) wide_cnt++;
         end
         prev_done = o_rx_done;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic lvl, input int clks);
      i_rx = lvl;
      repeat (clks) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
      drive_bit(1'b0, bit_clks);
      for (int i = 0; i < 8; i++) drive_bit(b[i], bit_clks);
      drive_bit(stop_lvl, bit_clks);
      i_rx = 1'b1;
   endtask

   task automatic idle(input int bits);
      drive_bit(1'b1, bits * bit_clks);
   endtask

   initial begin : main
      logic [7:0] b;
      i_rst = 1'b1;
      i_rx  = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_data", o_data, 8'h00);
      chk("rst_done", o_rx_done, 1'b0);
      chk("rst_ferr", o_frame_err, 1'b0);
      i_rst = 1'b0;
      idle(2);

      // 1: single frame 0xA5
      n0 = done_cnt;
      send_frame(8'hA5, 1'b1);
      chk("t1_cnt", done_cnt - n0, 1);
      chk("t1_cap", cap_data[n0], 8'hA5);
      chk("t1_data", o_data, 8'hA5);
      chk("t1_ferr", o_frame_err, 1'b0);
      chk("t1_width", wide_cnt, 0);
      idle(1);

      // 2: back-to-back frames
      exp2 = '{8'h00, 8'hFF, 8'h3C};
      n0 = done_cnt;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h3C, 1'b1);
      chk("t2_cnt", done_cnt - n0, 3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("t2_data%0d", i), cap_data[n0+i], exp2[i]);
         chk($sformatf("t2_ferr%0d", i), cap_err[n0+i], 1'b0);
      end
      idle(1);

      // 3: start glitch of 4 ticks is rejected
      n0 = done_cnt;
      drive_bit(1'b0, 4 * DIV);
      drive_bit(1'b1, 200 * DIV);
      chk("t3_cnt", done_cnt - n0, 0);
      chk("t3_data", o_data, 8'h3C);
      chk("t3_ferr", o_frame_err, 1'b0);

      // 4: stop bit low over its sample point, then a good frame
      n0 = done_cnt;
      b = 8'h81;
      drive_bit(1'b0, bit_clks);
      for (int i = 0; i < 8; i++) drive_bit(b[i], bit_clks);
      drive_bit(1'b0, (bit_clks * 3) / 4);
      idle(3);
      chk("t4_cnt", done_cnt - n0, 1);
      chk("t4_cap", cap_data[n0], 8'h81);
      chk("t4_cerr", cap_err[n0], 1'b1);
      chk("t4_data", o_data, 8'h81);
      chk("t4_ferr", o_frame_err, 1'b1);
      send_frame(8'h55, 1'b1);
      chk("t4b_cnt", done_cnt - n0, 2);
      chk("t4b_data", o_data, 8'h55);
      chk("t4b_ferr", o_frame_err, 1'b0);
      idle(1);

      // 5: reset during data bit 4 of 0x5A
      n0 = done_cnt;
      b = 8'h5A;
      drive_bit(1'b0, bit_clks);
      for (int i = 0; i < 4; i++) drive_bit(b[i], bit_clks);
      drive_bit(b[4], bit_clks / 2);
      i_rst = 1'b1;
      @(negedge clk);
      i_rst = 1'b0;
      chk("t5_rdata", o_data, 8'h00);
      chk("t5_rdone", o_rx_done, 1'b0);
      chk("t5_rferr", o_frame_err, 1'b0);
      idle(12);
      chk("t5_nodone", done_cnt - n0, 0);
      send_frame(8'h5A, 1'b1);
      chk("t5_cnt", done_cnt - n0, 1);
      chk("t5_data", o_data, 8'h5A);
      chk("t5_ferr", o_frame_err, 1'b0);

      // 6: tick held high, 16-clk bits, exact done timing
      tick_hi  = 1'b1;
      bit_clks = 16;
      idle(4);
      n0 = done_cnt;
      fork
         send_frame(8'hC3, 1'b1);
         begin
            repeat (154) @(negedge clk);
            chk("t6_early", o_rx_done, 1'b0);
            @(negedge clk);
            chk("t6_done", o_rx_done, 1'b1);
            chk("t6_data", o_data, 8'hC3);
            @(negedge clk);
            chk("t6_after", o_rx_done, 1'b0);
         end
      join
      idle(2);
      chk("t6_cnt", done_cnt - n0, 1);
      chk("width_all", wide_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
